// File: rtl/multicycle_pkg.sv
// Shared encodings for the LEGv8 multicycle controller: states, instruction
// classes, opcode patterns and the strobe/fault codes driven to the datapath.
package multicycle_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_NONE = 3'd0,
        CL_R    = 3'd1,
        CL_LD   = 3'd2,
        CL_ST   = 3'd3,
        CL_CBZ  = 3'd4,
        CL_B    = 3'd5
    } class_t;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
    localparam logic [5:0]  OP_B_PFX   = 6'b000101;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_PASS  = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_CBZ   = 2'd1;
    localparam logic [1:0] PC_B     = 2'd2;

    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
    localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

endpackage

// File: rtl/multicycle_controller_opcode_classifier.sv
// Combinational decode of the 11-bit LEGv8 opcode field into an instruction
// class; anything not recognised is flagged illegal.
module opcode_classifier
    import multicycle_pkg::*;
(
    input  logic [10:0] opcode,
    output class_t      cls,
    output logic        illegal
);

    always_comb begin
        cls = CL_NONE;
        if (opcode == OP_LDUR)
            cls = CL_LD;
        else if (opcode == OP_STUR)
            cls = CL_ST;
        else if (opcode == OP_ADD || opcode == OP_SUB ||
                 opcode == OP_AND || opcode == OP_ORR)
            cls = CL_R;
        else if (opcode[10:3] == OP_CBZ_PFX)
            cls = CL_CBZ;
        else if (opcode[10:5] == OP_B_PFX)
            cls = CL_B;
        illegal = (cls == CL_NONE);
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle sequencer for the LEGv8 datapath: FETCH/DECODE/EXEC/MEM/WB with
// memory-ready stalls, a memory-wait watchdog, illegal-opcode trap and retire count.
module multicycle_controller
    import multicycle_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       opcode,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              imem_req,
    output logic              ir_write,
    output logic              pc_write,
    output logic [1:0]        pc_src,
    output logic              reg_to_loc,
    output logic              alu_src,
    output logic [1:0]        alu_op,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_to_reg,
    output logic              reg_write,
    output logic              halted,
    output logic [1:0]        fault,
    output logic [CNT_W-1:0]  retired
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state, state_nxt;
    class_t            cls_q, cls_dec;
    logic              illegal;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        fault_q, fault_nxt;
    logic [CNT_W-1:0]  retired_q;
    logic              timed_out;
    logic              retire;

    opcode_classifier u_classifier (
        .opcode (opcode),
        .cls    (cls_dec),
        .illegal(illegal)
    );

    // A ready arriving on the last allowed wait cycle still wins over the watchdog.
    assign timed_out = !mem_ready && (wait_cnt == WAIT_W'(MEM_TIMEOUT));

    assign retire = (state == S_DECODE && cls_dec == CL_B)
                 || (state == S_EXEC   && cls_q == CL_CBZ)
                 || (state == S_MEM    && cls_q == CL_ST && mem_ready)
                 || (state == S_WB);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            cls_q     <= CL_NONE;
            wait_cnt  <= '0;
            retired_q <= '0;
            fault_q   <= FAULT_NONE;
        end else begin
            state     <= state_nxt;
            fault_q   <= fault_nxt;
            retired_q <= retired_q + CNT_W'(retire);
            if (state == S_DECODE)
                cls_q <= cls_dec;
            if ((state == S_FETCH || state == S_MEM) && state_nxt == state)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            else
                wait_cnt <= '0;
        end
    end

    always_comb begin
        state_nxt = state;
        fault_nxt = fault_q;
        case (state)
            S_FETCH: begin
                if (mem_ready)
                    state_nxt = S_DECODE;
                else if (timed_out) begin
                    state_nxt = S_HALT;
                    fault_nxt = FAULT_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (illegal) begin
                    state_nxt = S_HALT;
                    fault_nxt = FAULT_ILLEGAL;
                end else if (cls_dec == CL_B)
                    state_nxt = S_FETCH;
                else
                    state_nxt = S_EXEC;
            end
            S_EXEC: begin
                case (cls_q)
                    CL_R:         state_nxt = S_WB;
                    CL_LD, CL_ST: state_nxt = S_MEM;
                    default:      state_nxt = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ready)
                    state_nxt = (cls_q == CL_LD) ? S_WB : S_FETCH;
                else if (timed_out) begin
                    state_nxt = S_HALT;
                    fault_nxt = FAULT_TIMEOUT;
                end
            end
            S_WB:    state_nxt = S_FETCH;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_PLUS4;
        reg_to_loc = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        halted     = 1'b0;
        fault      = FAULT_NONE;
        if (!reset) begin
            fault = fault_q;
            case (state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_DECODE: begin
                    reg_to_loc = (cls_dec == CL_ST || cls_dec == CL_CBZ);
                    if (cls_dec == CL_B) begin
                        pc_write = 1'b1;
                        pc_src   = PC_B;
                    end
                end
                S_EXEC: begin
                    reg_to_loc = (cls_q == CL_ST || cls_q == CL_CBZ);
                    case (cls_q)
                        CL_R:    alu_op = ALU_RTYPE;
                        CL_LD, CL_ST: begin
                            alu_op  = ALU_ADD;
                            alu_src = 1'b1;
                        end
                        CL_CBZ: begin
                            alu_op   = ALU_PASS;
                            pc_write = zero;
                            pc_src   = PC_CBZ;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    reg_to_loc = (cls_q == CL_ST);
                    mem_read   = (cls_q == CL_LD);
                    mem_write  = (cls_q == CL_ST);
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (cls_q == CL_LD);
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: each driven cycle queues its hand-derived strobe vector,
// a negedge monitor pops and compares against the controller outputs.
module tb_multicycle_controller;

  typedef struct packed {
    logic        imem, ir, pcw;
    logic [1:0]  pcs;
    logic        rtl, asrc;
    logic [1:0]  aop;
    logic        mr, mw, m2r, rw, hlt;
    logic [1:0]  flt;
    logic [31:0] ret;
  } exp_t;

  localparam logic [10:0] ADD  = 11'b10001011000;
  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;
  localparam logic [10:0] CBZ  = 11'b10110100101;
  localparam logic [10:0] BR   = 11'b00010100011;
  localparam logic [10:0] BAD  = 11'b00000000000;

  logic        clk = 1'b0;
  logic        reset, zero, mem_ready;
  logic [10:0] opcode;
  logic        imem_req, ir_write, pc_write, reg_to_loc, alu_src;
  logic        mem_read, mem_write, mem_to_reg, reg_write, halted;
  logic [1:0]  pc_src, alu_op, fault;
  logic [31:0] retired;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .imem_req  (imem_req),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .reg_to_loc(reg_to_loc),
    .alu_src   (alu_src),
    .alu_op    (alu_op),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_to_reg(mem_to_reg),
    .reg_write (reg_write),
    .halted    (halted),
    .fault     (fault),
    .retired   (retired)
  );

  function automatic exp_t e_idle(input logic rtl, input logic [31:0] ret);
    exp_t e = '0;
    e.rtl = rtl;
    e.ret = ret;
    return e;
  endfunction

  function automatic exp_t e_fetch(input logic rdy, input logic [31:0] ret);
    exp_t e = '0;
    e.imem = 1'b1;
    e.ir   = rdy;
    e.pcw  = rdy;
    e.ret  = ret;
    return e;
  endfunction

  function automatic exp_t e_bdec(input logic [31:0] ret);
    exp_t e = '0;
    e.pcw = 1'b1;
    e.pcs = 2'd2;
    e.ret = ret;
    return e;
  endfunction

  function automatic exp_t e_exec(input logic [1:0] aop, input logic asrc, input logic pcw,
                                  input logic [1:0] pcs, input logic rtl, input logic [31:0] ret);
    exp_t e = '0;
    e.aop  = aop;
    e.asrc = asrc;
    e.pcw  = pcw;
    e.pcs  = pcs;
    e.rtl  = rtl;
    e.ret  = ret;
    return e;
  endfunction

  function automatic exp_t e_mem(input logic mr, input logic mw, input logic rtl, input logic [31:0] ret);
    exp_t e = '0;
    e.mr  = mr;
    e.mw  = mw;
    e.rtl = rtl;
    e.ret = ret;
    return e;
  endfunction

  function automatic exp_t e_wb(input logic m2r, input logic [31:0] ret);
    exp_t e = '0;
    e.rw  = 1'b1;
    e.m2r = m2r;
    e.ret = ret;
    return e;
  endfunction

  function automatic exp_t e_halt(input logic [1:0] flt, input logic [31:0] ret);
    exp_t e = '0;
    e.hlt = 1'b1;
    e.flt = flt;
    e.ret = ret;
    return e;
  endfunction

  task automatic cyc(input bit chk, input string nm, input logic rst, input logic [10:0] op,
                     input logic z, input logic rdy, input exp_t e);
    reset     = rst;
    opcode    = op;
    zero      = z;
    mem_ready = rdy;
    if (chk) begin
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t  want, got;
      string nm;
      want = exp_q.pop_front();
      nm   = name_q.pop_front();
      got  = {imem_req, ir_write, pc_write, pc_src, reg_to_loc, alu_src, alu_op,
              mem_read, mem_write, mem_to_reg, reg_write, halted, fault, retired};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL %s: got %h want %h", nm, got, want);
      end
    end
  end

  initial begin
    #1;
    cyc(0, "rst0", 1, ADD, 0, 1, e_idle(0, 0));
    cyc(1, "rst1", 1, ADD, 0, 1, e_idle(0, 0));

    total++;
    if (imem_req !== 1'b0 || ir_write !== 1'b0 || pc_write !== 1'b0 ||
        mem_read !== 1'b0 || mem_write !== 1'b0 || reg_write !== 1'b0 ||
        halted !== 1'b0 || fault !== 2'd0 || retired !== 32'd0) begin
      bad++;
      $display("FAIL reset_state: imem=%b ir=%b pcw=%b mr=%b mw=%b rw=%b hlt=%b flt=%0d ret=%0d",
               imem_req, ir_write, pc_write, mem_read, mem_write, reg_write,
               halted, fault, retired);
    end

    cyc(1, "add_fetch", 0, ADD, 0, 1, e_fetch(1, 0));
    cyc(1, "add_dec",   0, ADD, 0, 1, e_idle(0, 0));
    cyc(1, "add_exec",  0, ADD, 0, 1, e_exec(2'b10, 0, 0, 2'd0, 0, 0));
    cyc(1, "add_wb",    0, ADD, 0, 1, e_wb(0, 0));

    cyc(1, "ld_fetch", 0, LDUR, 0, 1, e_fetch(1, 1));
    cyc(1, "ld_dec",   0, LDUR, 0, 1, e_idle(0, 1));
    cyc(1, "ld_exec",  0, LDUR, 0, 1, e_exec(2'b00, 1, 0, 2'd0, 0, 1));
    for (int i = 0; i < 3; i++)
      cyc(1, "ld_mem_wait", 0, LDUR, 0, 0, e_mem(1, 0, 0, 1));
    cyc(1, "ld_mem_done", 0, LDUR, 0, 1, e_mem(1, 0, 0, 1));
    cyc(1, "ld_wb",       0, LDUR, 0, 1, e_wb(1, 1));

    cyc(1, "cbz1_fetch", 0, CBZ, 1, 1, e_fetch(1, 2));
    cyc(1, "cbz1_dec",   0, CBZ, 1, 0, e_idle(1, 2));
    cyc(1, "cbz1_exec",  0, CBZ, 1, 0, e_exec(2'b01, 0, 1, 2'd1, 1, 2));
    cyc(1, "cbz0_fetch", 0, CBZ, 0, 1, e_fetch(1, 3));
    cyc(1, "cbz0_dec",   0, CBZ, 0, 1, e_idle(1, 3));
    cyc(1, "cbz0_exec",  0, CBZ, 0, 1, e_exec(2'b01, 0, 0, 2'd1, 1, 3));

    cyc(1, "b_fetch",   0, BR, 0, 1, e_fetch(1, 4));
    cyc(1, "b_dec",     0, BR, 0, 0, e_bdec(4));
    cyc(1, "ill_fetch", 0, BAD, 0, 1, e_fetch(1, 5));
    cyc(1, "ill_dec",   0, BAD, 0, 1, e_idle(0, 5));
    for (int i = 0; i < 20; i++)
      cyc(1, "ill_halt", 0, BAD, i[0], i[1], e_halt(2'd1, 5));
    cyc(1, "rst_halt", 1, BAD, 0, 1, e_idle(0, 5));

    for (int i = 0; i < 16; i++)
      cyc(1, "to_fetch_wait", 0, ADD, 0, 0, e_fetch(0, 0));
    for (int i = 0; i < 3; i++)
      cyc(1, "to_fetch_halt", 0, ADD, 0, 1, e_halt(2'd2, 0));

    total++;
    if (halted !== 1'b1 || fault !== 2'd2 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL expired_wait: halted=%b fault=%0d imem_req=%b", halted, fault, imem_req);
    end

    cyc(1, "rst_to", 1, ADD, 0, 0, e_idle(0, 0));

    for (int i = 0; i < 15; i++)
      cyc(1, "edge_fetch_wait", 0, ADD, 0, 0, e_fetch(0, 0));
    cyc(1, "edge_fetch_last", 0, ADD, 0, 1, e_fetch(1, 0));
    cyc(1, "edge_dec",        0, ADD, 0, 1, e_idle(0, 0));
    cyc(1, "edge_exec",       0, ADD, 0, 1, e_exec(2'b10, 0, 0, 2'd0, 0, 0));
    cyc(1, "edge_wb",         0, ADD, 0, 1, e_wb(0, 0));

    cyc(1, "st_fetch",   0, STUR, 0, 1, e_fetch(1, 1));
    cyc(1, "st_dec",     0, STUR, 0, 1, e_idle(1, 1));
    cyc(1, "st_exec",    0, STUR, 0, 1, e_exec(2'b00, 1, 0, 2'd0, 1, 1));
    cyc(1, "st_mem_rst", 1, STUR, 0, 1, e_idle(0, 1));
    cyc(1, "st2_fetch",  0, STUR, 0, 1, e_fetch(1, 0));
    cyc(1, "st2_dec",    0, STUR, 0, 1, e_idle(1, 0));
    cyc(1, "st2_exec",   0, STUR, 0, 1, e_exec(2'b00, 1, 0, 2'd0, 1, 0));
    cyc(1, "st2_mem_wait", 0, STUR, 0, 0, e_mem(0, 1, 1, 0));
    cyc(1, "st2_mem_done", 0, STUR, 0, 1, e_mem(0, 1, 1, 0));
    cyc(1, "st3_fetch",  0, STUR, 0, 1, e_fetch(1, 1));
    cyc(1, "st3_dec",    0, STUR, 0, 1, e_idle(1, 1));
    cyc(1, "st3_exec",   0, STUR, 0, 1, e_exec(2'b00, 1, 0, 2'd0, 1, 1));
    for (int i = 0; i < 16; i++)
      cyc(1, "st3_mem_wait", 0, STUR, 0, 0, e_mem(0, 1, 1, 1));
    for (int i = 0; i < 2; i++)
      cyc(1, "st3_halt", 0, STUR, 0, 1, e_halt(2'd2, 1));

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
